// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the byte PC, issues BRAM word reads, returns (pc, instr) to decode.
// Latency: issue in cycle N -> out_valid in cycle N+2; 1 instr/cycle sustained.
// Backpressure: out_ready low fills the 2-entry skid buffer, then imem_ena holds low.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_ena,
    output logic [31:0] imem_addra,
    input  logic [31:0] imem_douta,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] issue_pc;
    logic        inflight;
    logic [1:0]  count;
    entry_t      ent0;
    entry_t      ent1;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occ;
    logic [1:0]  base;
    logic [1:0]  count_n;
    entry_t      ent0_n;
    entry_t      ent1_n;
    entry_t      new_ent;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    assign out_valid = (count != 2'd0);
    assign out_pc    = ent0.pc;
    assign out_instr = ent0.instr;
    assign pop       = out_valid & out_ready;

    // Occupancy seen next cycle once the outstanding read lands; a pop implies count>=1.
    assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue = !rst && !redirect_valid && !halt &&
                   (state == RUN || state == HALTED) && (occ < 3'(BUF_DEPTH));
    assign push  = inflight & ~redirect_valid;

    assign imem_ena   = issue;
    assign imem_addra = issue ? {2'b00, pc[31:2]} : 32'h0;

    always_comb begin
        new_ent = '{pc: issue_pc, instr: imem_douta};
        ent0_n  = ent0;
        ent1_n  = ent1;
        base    = count;
        if (pop) begin
            ent0_n = ent1;
            base   = count - 2'd1;
        end
        if (push) begin
            if (base == 2'd0) ent0_n = new_ent;
            else              ent1_n = new_ent;
        end
        count_n = base + {1'b0, push};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            halted   <= 1'b0;
            pc       <= RESET_PC;
            issue_pc <= 32'h0;
            inflight <= 1'b0;
            count    <= 2'd0;
            ent0     <= '0;
            ent1     <= '0;
        end else begin
            ent0     <= ent0_n;
            ent1     <= ent1_n;
            inflight <= issue;
            if (redirect_valid) begin
                count <= 2'd0;
                pc    <= {redirect_pc[31:2], 2'b00};
            end else begin
                count <= count_n;
                if (issue) begin
                    pc       <= pc + 32'd4;
                    issue_pc <= pc;
                end
            end
            // A redirect outside RUN only flushes; the halt sequencing is left alone.
            if (!(redirect_valid && state != RUN)) begin
                case (state)
                    RUN: begin
                        if (halt) begin
                            if (inflight) begin
                                state <= DRAIN;
                            end else begin
                                state  <= HALTED;
                                halted <= 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                    HALTED: begin
                        if (!halt) begin
                            state  <= RUN;
                            halted <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
